avalon_timer_driver: RTL

Avalon-MM initiator that owns the 16-bit interval timer slave in the timer/display subsystem. It programs the timer through its register map (status 0, control 1, snap 4/5) and services the timer's 1 s interrupt. It accumulates elapsed playback time as minutes:seconds for the display path, under start/stop/clear commands from the player control logic.

---
 rtl/avalon_timer_driver.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/avalon_timer_driver.sv
// Avalon-MM master for the 16-bit interval timer; accumulates mm:ss playback time from its 1 s irq.
// Define TIMER_DRV_STATUS_CHECK_EN to read back status TO before counting an irq.
module avalon_timer_driver #(
  parameter int MIN_MAX = 99,
  parameter int SEC_MAX = 59
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cmd_clear,
  input  logic        timer_irq,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  output logic        running,
  output logic [5:0]  seconds,
  output logic [6:0]  minutes,
  output logic        tick
);

  localparam logic [5:0]  LP_SEC_MAX     = 6'(SEC_MAX);
  localparam logic [6:0]  LP_MIN_MAX     = 7'(MIN_MAX);
  localparam logic [2:0]  LP_ADDR_STATUS = 3'd0;
  localparam logic [2:0]  LP_ADDR_CTRL   = 3'd1;
  localparam logic [15:0] LP_CTRL_START  = 16'h0007;
  localparam logic [15:0] LP_CTRL_STOP   = 16'h0008;

  typedef enum logic [2:0] {
    IDLE,
    WR_START,
    RUN,
`ifdef TIMER_DRV_STATUS_CHECK_EN
    RD_STATUS,
    RD_WAIT,
`endif
    CLR_TO,
    CLR_WAIT,
    WR_STOP
  } state_t;

  state_t r_state;
  state_t w_nextState;
  logic   r_stopPending;
  logic   w_inService;
  logic   w_increment;
  logic   w_unused_readdata;

`ifdef TIMER_DRV_STATUS_CHECK_EN
  assign w_unused_readdata = ^avm_readdata[15:1];
`else
  assign w_unused_readdata = ^avm_readdata;
`endif

  // w_inService marks cycles where a stop must wait until the current tick is finished.
  always_comb begin
    w_nextState = r_state;
    w_inService = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_start) w_nextState = WR_START;
      end
      WR_START: w_nextState = RUN;
      RUN: begin
        w_inService = timer_irq;
        if (timer_irq) begin
`ifdef TIMER_DRV_STATUS_CHECK_EN
          w_nextState = RD_STATUS;
`else
          w_nextState = CLR_TO;
`endif
        end else if (cmd_stop || r_stopPending) begin
          w_nextState = WR_STOP;
        end
      end
`ifdef TIMER_DRV_STATUS_CHECK_EN
      RD_STATUS: begin
        w_inService = 1'b1;
        w_nextState = RD_WAIT;
      end
      RD_WAIT: begin
        w_inService = 1'b1;
        w_nextState = avm_readdata[0] ? CLR_TO : RUN;
      end
`endif
      CLR_TO: begin
        w_inService = 1'b1;
        w_nextState = CLR_WAIT;
      end
      CLR_WAIT: begin
        w_inService = 1'b1;
        w_nextState = (r_stopPending || cmd_stop) ? WR_STOP : RUN;
      end
      WR_STOP:  w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  assign w_increment = (w_nextState == CLR_TO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_stopPending <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == WR_STOP)
        r_stopPending <= 1'b0;
      else if (cmd_stop && w_inService)
        r_stopPending <= 1'b1;
    end
  end

  // Bus strobes are decoded from the next state so each access occupies exactly its state's cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= 3'd0;
      avm_writedata  <= 16'h0000;
      running        <= 1'b0;
    end else begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= 3'd0;
      avm_writedata  <= 16'h0000;
      case (w_nextState)
        WR_START: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= LP_ADDR_CTRL;
          avm_writedata  <= LP_CTRL_START;
          running        <= 1'b1;
        end
`ifdef TIMER_DRV_STATUS_CHECK_EN
        RD_STATUS: begin
          avm_chipselect <= 1'b1;
          avm_address    <= LP_ADDR_STATUS;
        end
`endif
        CLR_TO: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= LP_ADDR_STATUS;
        end
        WR_STOP: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= LP_ADDR_CTRL;
          avm_writedata  <= LP_CTRL_STOP;
          running        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // A clear beats a same-cycle increment, but the tick still reports the serviced second.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seconds <= 6'd0;
      minutes <= 7'd0;
      tick    <= 1'b0;
    end else begin
      tick <= w_increment;
      if (cmd_clear) begin
        seconds <= 6'd0;
        minutes <= 7'd0;
      end else if (w_increment) begin
        if (seconds == LP_SEC_MAX) begin
          seconds <= 6'd0;
          minutes <= (minutes == LP_MIN_MAX) ? 7'd0 : minutes + 7'd1;
        end else begin
          seconds <= seconds + 6'd1;
        end
      end
    end
  end

endmodule
